// File: rtl/cpu_clk_sched_pkg.sv
// Shared encodings and limits for the CPU clock-enable scheduler.
package cpu_clk_sched_pkg;

  // Scheduler state, also driven straight out on the mode port.
  typedef enum logic [1:0] {
    MODE_HALT  = 2'd0,
    MODE_RUN   = 2'd1,
    MODE_STEP  = 2'd2,
    MODE_BURST = 2'd3
  } mode_t;

  // Shortest legal enable period; keeps cpu_ce from ever being high twice in a row.
  localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/cpu_clk_phase.sv
// Phase counter with pending/shadow period registers and wrap detect.
// The shadow period only changes at a wrap or on clear, so a period in
// progress is never truncated or stretched by a configuration write.
module cpu_clk_phase
  import cpu_clk_sched_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int PERIOD_DEFAULT = 100
) (
  input  logic             clk_100M,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic             i_cfg_we,
  input  logic [CNT_W-1:0] i_cfg_period,
  output logic             o_wrap
);

  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(PERIOD_DEFAULT);

  logic [CNT_W-1:0] r_pend;
  logic [CNT_W-1:0] r_shadow;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_clamped;

  assign w_clamped = (i_cfg_period < MIN_P) ? MIN_P : i_cfg_period;

  // Last count of the active period; only meaningful while counting.
  assign o_wrap = i_enable && (r_cnt == (r_shadow - CNT_W'(1)));

  // Pending capture, shadow hand-over at wrap/clear, and the phase count itself.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      r_pend   <= DEF_P;
      r_shadow <= DEF_P;
      r_cnt    <= '0;
    end else begin
      if (i_cfg_we) r_pend <= w_clamped;
      if (i_clear) begin
        // Clear happens on entry from HALT (and on halt, where the shadow is unused).
        r_cnt    <= '0;
        r_shadow <= r_pend;
      end else if (o_wrap) begin
        r_cnt    <= '0;
        r_shadow <= r_pend;
      end else if (i_enable) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_clk_sched.sv
// CPU clock-enable scheduler: HALT/RUN/STEP/BURST control around a phase
// counter, plus a free-running count of issued enables.
// Commands are single-cycle pulses with no handshake; a command that is not
// legal in the current state is dropped. Priority: halt > step > burst > run.
module cpu_clk_sched
  import cpu_clk_sched_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int TICK_W         = 32,
  parameter int PERIOD_DEFAULT = 100,
  parameter bit START_RUN      = 1'b0
) (
  input  logic              clk_100M,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic              cmd_run,
  input  logic              cmd_halt,
  input  logic              cmd_step,
  input  logic              cmd_burst,
  input  logic [CNT_W-1:0]  burst_len,
  output logic              cpu_ce,
  output logic              busy,
  output logic [1:0]        mode,
  output logic [TICK_W-1:0] tick_count
);

  mode_t             r_state;
  mode_t             w_state_n;
  logic [CNT_W-1:0]  r_rem;
  logic [CNT_W-1:0]  w_rem_n;
  logic              r_ce;
  logic              w_ce_n;
  logic              w_clear;
  logic              w_active;
  logic              w_wrap;
  logic [TICK_W-1:0] r_ticks;

  assign w_active = (r_state != MODE_HALT);

  cpu_clk_phase #(
    .CNT_W          (CNT_W),
    .PERIOD_DEFAULT (PERIOD_DEFAULT)
  ) u_phase (
    .clk_100M     (clk_100M),
    .rst          (rst),
    .i_clear      (w_clear),
    .i_enable     (w_active),
    .i_cfg_we     (cfg_we),
    .i_cfg_period (cfg_period),
    .o_wrap       (w_wrap)
  );

  // Next-state, burst bookkeeping and enable generation.
  always_comb begin
    w_state_n = r_state;
    w_rem_n   = r_rem;
    w_clear   = 1'b0;
    w_ce_n    = 1'b0;
    case (r_state)
      MODE_HALT: begin
        if (cmd_halt) begin
          w_clear = 1'b1;
        end else if (cmd_step) begin
          w_state_n = MODE_STEP;
          w_clear   = 1'b1;
        end else if (cmd_burst && (burst_len != '0)) begin
          w_state_n = MODE_BURST;
          w_rem_n   = burst_len;
          w_clear   = 1'b1;
        end else if (cmd_run) begin
          w_state_n = MODE_RUN;
          w_clear   = 1'b1;
        end
      end
      default: begin
        if (cmd_halt) begin
          // Halt beats a wrap in the same cycle: no enable follows.
          w_state_n = MODE_HALT;
          w_clear   = 1'b1;
        end else if (w_wrap) begin
          w_ce_n = 1'b1;
          if (r_state == MODE_STEP) begin
            w_state_n = MODE_HALT;
          end else if (r_state == MODE_BURST) begin
            w_rem_n = r_rem - CNT_W'(1);
            if (r_rem == CNT_W'(1)) w_state_n = MODE_HALT;
          end
        end
      end
    endcase
  end

  // State, burst remaining, registered enable and retired-enable counter.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      r_state <= START_RUN ? MODE_RUN : MODE_HALT;
      r_rem   <= '0;
      r_ce    <= 1'b0;
      r_ticks <= '0;
    end else begin
      r_state <= w_state_n;
      r_rem   <= w_rem_n;
      r_ce    <= w_ce_n;
      if (w_ce_n) r_ticks <= r_ticks + TICK_W'(1);
    end
  end

  assign cpu_ce     = r_ce;
  assign busy       = (r_state != MODE_HALT);
  assign mode       = r_state;
  assign tick_count = r_ticks;

endmodule
